// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared TX frame state encoding and frame constants
package uart_tx_pkg;
  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_TX_START_BIT = 3'd1,
    s_TX_DATA_BITS = 3'd2,
    s_TX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_baud_counter.sv
// uart_tx_baud_counter: per-bit cycle counter that wraps at CLKS_PER_BIT-1
//  i_Clock, i_Reset : clock, synchronous active-high reset
//  i_Clear          : force count to 0 on the next edge (state change)
//  i_Run            : advance the count this cycle
//  o_Count          : current count, 0..CLKS_PER_BIT-1
//  o_Tick           : high while o_Count is on the last cycle of a bit
module uart_tx_baud_counter #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Clear,
  input  logic        i_Run,
  output logic [15:0] o_Count,
  output logic        o_Tick
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  assign o_Tick = o_Count == LAST;
  always_ff @(posedge i_Clock)
    o_Count <= (i_Reset || i_Clear || o_Tick) ? '0 : i_Run ? o_Count + 16'd1 : o_Count;
endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// uart_tx_frame_sequencer: sequences 8N1/8N2 UART frames from a one-byte holding register
//  i_Clock, i_Reset : clock, synchronous active-high reset
//  i_Tx_DV, i_Tx_Byte : host byte valid and data, taken when o_Tx_Ready is high
//  o_Tx_Ready       : holding register empty
//  o_Tx_Serial      : registered serial line, idle high
//  o_Tx_Active      : high in START, DATA and STOP states
//  o_Tx_Done        : one-cycle pulse in CLEANUP
//  o_State, o_Clock_Count, o_Bit_Index : live FSM state, baud count and data-bit index
module uart_tx_frame_sequencer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int STOP_BITS    = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Tx_DV,
  input  logic [7:0]  i_Tx_Byte,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic [2:0]  o_State,
  output logic [15:0] o_Clock_Count,
  output logic [2:0]  o_Bit_Index
);
  state_t     state, state_n;
  logic [7:0] hold, shift, shift_n;
  logic [2:0] idx, idx_n;
  logic       stop_cnt, stop_n;
  logic       full, push, pop;
  logic       serial_n, tick, run;
  assign push = i_Tx_DV && !full;
  assign run  = state == s_TX_START_BIT || state == s_TX_DATA_BITS || state == s_TX_STOP_BIT;
  uart_tx_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Clear(state_n != state),
    .i_Run  (run),
    .o_Count(o_Clock_Count),
    .o_Tick (tick)
  );
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    stop_n  = stop_cnt;
    pop     = 1'b0;
    case (state)
      s_IDLE: if (full) begin
        state_n = s_TX_START_BIT;
        shift_n = hold;
        pop     = 1'b1;
      end
      s_TX_START_BIT: if (tick) begin
        state_n = s_TX_DATA_BITS;
        idx_n   = '0;
      end
      s_TX_DATA_BITS: if (tick) begin
        idx_n   = idx + 3'd1;
        state_n = idx == 3'(DATA_BITS - 1) ? s_TX_STOP_BIT : s_TX_DATA_BITS;
      end
      s_TX_STOP_BIT: if (tick) begin
        stop_n  = stop_cnt == 1'(STOP_BITS - 1) ? 1'b0 : stop_cnt + 1'b1;
        state_n = stop_cnt == 1'(STOP_BITS - 1) ? s_CLEANUP : s_TX_STOP_BIT;
      end
      s_CLEANUP: state_n = s_IDLE;
      default:   state_n = s_IDLE;
    endcase
    // serial is registered from next-state values so the line lines up with the state register
    serial_n = state_n == s_TX_START_BIT ? 1'b0 :
               state_n == s_TX_DATA_BITS ? shift_n[idx_n] : 1'b1;
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= s_IDLE;
      shift       <= '0;
      hold        <= '0;
      full        <= 1'b0;
      idx         <= '0;
      stop_cnt    <= 1'b0;
      o_Tx_Serial <= 1'b1;
    end else begin
      state       <= state_n;
      shift       <= shift_n;
      idx         <= idx_n;
      stop_cnt    <= stop_n;
      o_Tx_Serial <= serial_n;
      full        <= push || (full && !pop);
      if (push) hold <= i_Tx_Byte;
    end
  end
  assign o_Tx_Ready  = !full;
  assign o_Tx_Active = run;
  assign o_Tx_Done   = state == s_CLEANUP;
  assign o_State     = state;
  assign o_Bit_Index = idx;
endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// tb_uart_tx_frame_sequencer: scoreboard bench for the UART TX frame sequencer
module tb_uart_tx_frame_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        dv_a = 1'b0, dv_b = 1'b0;
  logic [7:0]  byte_a = '0, byte_b = '0;
  logic        rdy_a, ser_a, act_a, done_a, rdy_b, ser_b, act_b, done_b;
  logic [2:0]  st_a, idx_a, st_b, idx_b;
  logic [15:0] cnt_a, cnt_b;
  int          tests = 0, fails = 0, cyc = 0;
  logic [7:0]  sb[$];
  int          mon_t = -1;
  logic [7:0]  mon_byte = '0, exp_byte;

  uart_tx_frame_sequencer #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
    .o_Tx_Ready(rdy_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(done_a),
    .o_State(st_a), .o_Clock_Count(cnt_a), .o_Bit_Index(idx_a));

  uart_tx_frame_sequencer #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
    .o_Tx_Ready(rdy_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(done_b),
    .o_State(st_b), .o_Clock_Count(cnt_b), .o_Bit_Index(idx_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // frame decoder for dut_a: mon_t=0 is the first start-bit cycle, bits are 4 cycles wide
  always @(negedge clk) begin
    if (rst) mon_t = -1;
    else if (mon_t < 0) begin
      if (ser_a === 1'b0) mon_t = 0;
    end else begin
      mon_t++;
      if (mon_t >= 6 && mon_t <= 34 && (mon_t % 4) == 2) mon_byte[(mon_t - 6) / 4] = ser_a;
      if (mon_t == 38) begin
        tests++;
        if (ser_a !== 1'b1) begin fails++; $display("FAIL mon_stop got=%b exp=1", ser_a); end
      end
      if (mon_t == 39) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL mon_unexpected_frame got=%h exp=none", mon_byte);
        end else begin
          exp_byte = sb.pop_front();
          if (mon_byte !== exp_byte) begin
            fails++; $display("FAIL mon_byte got=%h exp=%h", mon_byte, exp_byte);
          end
        end
        mon_t = -1;
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests += 7;
    if (ser_a !== 1'b1)  begin fails++; $display("FAIL rst_serial got=%b exp=1", ser_a); end
    if (rdy_a !== 1'b1)  begin fails++; $display("FAIL rst_ready got=%b exp=1", rdy_a); end
    if (st_a !== 3'd0)   begin fails++; $display("FAIL rst_state got=%0d exp=0", st_a); end
    if (cnt_a !== 16'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", cnt_a); end
    if (idx_a !== 3'd0)  begin fails++; $display("FAIL rst_index got=%0d exp=0", idx_a); end
    if (done_a !== 1'b0 || act_a !== 1'b0) begin
      fails++; $display("FAIL rst_done_active got=%b%b exp=00", done_a, act_a);
    end
    if (ser_b !== 1'b1 || rdy_b !== 1'b1) begin
      fails++; $display("FAIL rst_b got=%b%b exp=11", ser_b, rdy_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [7:0] b = 8'hA5;
    int n, t;
    logic es, ea, ed, er;
    logic [2:0] est;
    n = cyc; dv_a = 1'b1; byte_a = b; sb.push_back(b);
    @(negedge clk); dv_a = 1'b0;
    for (int k = 0; k < 44; k++) begin
      t = cyc - n;
      es  = (t >= 2 && t <= 5) ? 1'b0 : (t >= 6 && t <= 37) ? b[(t - 6) / 4] : 1'b1;
      ea  = t >= 2 && t <= 41;
      ed  = t == 42;
      er  = t != 1;
      est = t < 2 ? 3'd0 : t < 6 ? 3'd1 : t < 38 ? 3'd2 : t < 42 ? 3'd3 : t == 42 ? 3'd4 : 3'd0;
      tests += 5;
      if (ser_a !== es)  begin fails++; $display("FAIL single_serial t=%0d got=%b exp=%b", t, ser_a, es); end
      if (act_a !== ea)  begin fails++; $display("FAIL single_active t=%0d got=%b exp=%b", t, act_a, ea); end
      if (done_a !== ed) begin fails++; $display("FAIL single_done t=%0d got=%b exp=%b", t, done_a, ed); end
      if (rdy_a !== er)  begin fails++; $display("FAIL single_ready t=%0d got=%b exp=%b", t, rdy_a, er); end
      if (st_a !== est)  begin fails++; $display("FAIL single_state t=%0d got=%0d exp=%0d", t, st_a, est); end
      if (t >= 6 && t <= 37) begin
        tests += 2;
        if (idx_a !== 3'((t - 6) / 4)) begin
          fails++; $display("FAIL single_index t=%0d got=%0d exp=%0d", t, idx_a, (t - 6) / 4);
        end
        if (cnt_a !== 16'((t - 6) % 4)) begin
          fails++; $display("FAIL single_count t=%0d got=%0d exp=%0d", t, cnt_a, (t - 6) % 4);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n, t;
    logic ed;
    n = cyc; dv_a = 1'b1; byte_a = 8'h00; sb.push_back(8'h00);
    @(negedge clk); dv_a = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (rdy_a !== 1'b1) begin fails++; $display("FAIL b2b_ready_before got=%b exp=1", rdy_a); end
    dv_a = 1'b1; byte_a = 8'hFF; sb.push_back(8'hFF);
    @(negedge clk); dv_a = 1'b0;
    tests++;
    if (rdy_a !== 1'b0) begin fails++; $display("FAIL b2b_ready_after got=%b exp=0", rdy_a); end
    for (int k = 0; k < 86; k++) begin
      t = cyc - n;
      ed = t == 42 || t == 84;
      tests++;
      if (done_a !== ed) begin fails++; $display("FAIL b2b_done t=%0d got=%b exp=%b", t, done_a, ed); end
      if (t == 43 || t == 44) begin
        tests += 2;
        if (st_a !== (t == 43 ? 3'd0 : 3'd1)) begin
          fails++; $display("FAIL b2b_gap_state t=%0d got=%0d exp=%0d", t, st_a, t - 43);
        end
        if (ser_a !== (t == 43)) begin
          fails++; $display("FAIL b2b_gap_serial t=%0d got=%b exp=%b", t, ser_a, t == 43);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overrun;
    n_overrun: begin
      int n;
      n = cyc; dv_a = 1'b1; byte_a = 8'h11; sb.push_back(8'h11);
      @(negedge clk); dv_a = 1'b0;
      repeat (3) @(negedge clk);
      dv_a = 1'b1; byte_a = 8'h22; sb.push_back(8'h22);
      @(negedge clk); dv_a = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (rdy_a !== 1'b0) begin fails++; $display("FAIL ovr_ready_held got=%b exp=0", rdy_a); end
      dv_a = 1'b1; byte_a = 8'h3C;
      @(negedge clk); dv_a = 1'b0;
      tests++;
      if (rdy_a !== 1'b0) begin fails++; $display("FAIL ovr_ready_after got=%b exp=0", rdy_a); end
      while (cyc - n < 130) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL ovr_pending got=%0d exp=0", sb.size()); end
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    dv_a = 1'b1; byte_a = 8'h5A; sb.push_back(8'h5A);
    @(negedge clk); dv_a = 1'b0;
    repeat (3) @(negedge clk);
    dv_a = 1'b1; byte_a = 8'h66; sb.push_back(8'h66);
    @(negedge clk); dv_a = 1'b0;
    repeat (14) @(negedge clk);
    tests += 2;
    if (st_a !== 3'd2) begin fails++; $display("FAIL mid_pre_state got=%0d exp=2", st_a); end
    if (idx_a !== 3'd3) begin fails++; $display("FAIL mid_pre_index got=%0d exp=3", idx_a); end
    rst = 1'b1;
    @(negedge clk);
    tests += 5;
    if (st_a !== 3'd0)   begin fails++; $display("FAIL mid_state got=%0d exp=0", st_a); end
    if (ser_a !== 1'b1)  begin fails++; $display("FAIL mid_serial got=%b exp=1", ser_a); end
    if (rdy_a !== 1'b1)  begin fails++; $display("FAIL mid_ready got=%b exp=1", rdy_a); end
    if (cnt_a !== 16'd0 || idx_a !== 3'd0) begin
      fails++; $display("FAIL mid_count_index got=%0d/%0d exp=0/0", cnt_a, idx_a);
    end
    if (done_a !== 1'b0) begin fails++; $display("FAIL mid_done got=%b exp=0", done_a); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (60) begin
      @(negedge clk);
      if (done_a !== 1'b0 || ser_a !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL mid_quiet got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_two_stop;
    logic [7:0] b = 8'h81;
    int n, t;
    logic es, ed;
    n = cyc; dv_b = 1'b1; byte_b = b;
    @(negedge clk); dv_b = 1'b0;
    for (int k = 0; k < 27; k++) begin
      t = cyc - n;
      es = (t >= 2 && t <= 3) ? 1'b0 : (t >= 4 && t <= 19) ? b[(t - 4) / 2] : 1'b1;
      ed = t == 24;
      tests += 2;
      if (ser_b !== es)  begin fails++; $display("FAIL stop2_serial t=%0d got=%b exp=%b", t, ser_b, es); end
      if (done_b !== ed) begin fails++; $display("FAIL stop2_done t=%0d got=%b exp=%b", t, done_b, ed); end
      if (t >= 20 && t <= 24) begin
        tests++;
        if (st_b !== (t == 24 ? 3'd4 : 3'd3)) begin
          fails++; $display("FAIL stop2_state t=%0d got=%0d exp=%0d", t, st_b, t == 24 ? 4 : 3);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_two_stop;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL final_pending got=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
